// File: rtl/path_delay_scheduler.sv
// Delay-based Trojan screening sequencer: per path, settle low, launch 0->1, count until rise, window-check.
// Optional FALL_EDGE_TEST_EN adds a 1->0 measurement after each rise capture.
`timescale 1ns/1ps

module path_delay_scheduler #(
    parameter int NUM_PATHS  = 8,
    parameter int CNT_W      = 12,
    parameter int SETTLE_CYC = 16,
    parameter int TIMEOUT    = 4000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         path_result,
    input  logic [CNT_W-1:0]             thresh_lo,
    input  logic [CNT_W-1:0]             thresh_hi,
    output logic [$clog2(NUM_PATHS)-1:0] path_sel,
    output logic                         path_drive,
    output logic [CNT_W-1:0]             delay_cnt,
    output logic                         cnt_valid,
    output logic [NUM_PATHS-1:0]         trojan_flag,
    output logic                         timeout_err,
    output logic                         busy,
    output logic                         done
);

    localparam int SEL_W = $clog2(NUM_PATHS);
    localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LP_SETTLE  = CNT_W'(SETTLE_CYC);
    localparam logic [SEL_W-1:0] LP_LAST    = SEL_W'(NUM_PATHS - 1);

`ifdef FALL_EDGE_TEST_EN
    typedef enum logic [3:0] {
        S_IDLE, S_SETTLE, S_LAUNCH, S_CAPTURE, S_NEXT, S_FINISH,
        S_FSETTLE, S_FLAUNCH, S_FCAPTURE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_LAUNCH, S_CAPTURE, S_NEXT, S_FINISH
    } state_t;
`endif

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_timed_out;
    logic [SEL_W-1:0]       r_path_sel;
    logic                   r_path_drive;
    logic [CNT_W-1:0]       r_delay_cnt;
    logic                   r_cnt_valid;
    logic [NUM_PATHS-1:0]   r_trojan_flag;
    logic                   r_timeout_err;
    logic                   r_busy;
    logic                   r_done;
    logic                   w_fail;

    // Inclusive window; an inverted window (lo > hi) fails every count.
    always_comb begin
        w_fail = (r_delay_cnt < thresh_lo) | (r_delay_cnt > thresh_hi) | r_timed_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_timed_out   <= 1'b0;
            r_path_sel    <= '0;
            r_path_drive  <= 1'b0;
            r_delay_cnt   <= '0;
            r_cnt_valid   <= 1'b0;
            r_trojan_flag <= '0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_cnt_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state       <= S_SETTLE;
                        r_trojan_flag <= '0;
                        r_timeout_err <= 1'b0;
                        r_timed_out   <= 1'b0;
                        r_path_sel    <= '0;
                        r_path_drive  <= 1'b0;
                        r_busy        <= 1'b1;
                        r_cnt         <= CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (r_cnt >= LP_SETTLE && !path_result) begin
                        r_state      <= S_LAUNCH;
                        r_path_drive <= 1'b1;
                        r_cnt        <= CNT_W'(1);
                    end else if (r_cnt >= LP_TIMEOUT) begin
                        r_state       <= S_CAPTURE;
                        r_delay_cnt   <= LP_TIMEOUT;
                        r_cnt_valid   <= 1'b1;
                        r_timed_out   <= 1'b1;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LAUNCH: begin
                    if (path_result) begin
                        r_state     <= S_CAPTURE;
                        r_delay_cnt <= r_cnt;
                        r_cnt_valid <= 1'b1;
                    end else if (r_cnt >= LP_TIMEOUT) begin
                        r_state       <= S_CAPTURE;
                        r_delay_cnt   <= LP_TIMEOUT;
                        r_cnt_valid   <= 1'b1;
                        r_timed_out   <= 1'b1;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_trojan_flag[r_path_sel] <= w_fail;
                    r_timed_out               <= 1'b0;
`ifdef FALL_EDGE_TEST_EN
                    // Drive stays high so the fall settle phase starts from the risen path.
                    r_state      <= S_FSETTLE;
                    r_path_drive <= 1'b1;
                    r_cnt        <= CNT_W'(1);
`else
                    r_state      <= S_NEXT;
                    r_path_drive <= 1'b0;
`endif
                end
`ifdef FALL_EDGE_TEST_EN
                S_FSETTLE: begin
                    if (r_cnt >= LP_SETTLE && path_result) begin
                        r_state      <= S_FLAUNCH;
                        r_path_drive <= 1'b0;
                        r_cnt        <= CNT_W'(1);
                    end else if (r_cnt >= LP_TIMEOUT) begin
                        r_state       <= S_FCAPTURE;
                        r_delay_cnt   <= LP_TIMEOUT;
                        r_cnt_valid   <= 1'b1;
                        r_timed_out   <= 1'b1;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FLAUNCH: begin
                    if (!path_result) begin
                        r_state     <= S_FCAPTURE;
                        r_delay_cnt <= r_cnt;
                        r_cnt_valid <= 1'b1;
                    end else if (r_cnt >= LP_TIMEOUT) begin
                        r_state       <= S_FCAPTURE;
                        r_delay_cnt   <= LP_TIMEOUT;
                        r_cnt_valid   <= 1'b1;
                        r_timed_out   <= 1'b1;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FCAPTURE: begin
                    r_trojan_flag[r_path_sel] <= r_trojan_flag[r_path_sel] | w_fail;
                    r_timed_out               <= 1'b0;
                    r_path_drive              <= 1'b0;
                    r_state                   <= S_NEXT;
                end
`endif
                S_NEXT: begin
                    if (r_path_sel == LP_LAST) begin
                        r_state <= S_FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= S_SETTLE;
                        r_path_sel <= r_path_sel + 1'b1;
                        r_cnt      <= CNT_W'(1);
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign path_sel    = r_path_sel;
    assign path_drive  = r_path_drive;
    assign delay_cnt   = r_delay_cnt;
    assign cnt_valid   = r_cnt_valid;
    assign trojan_flag = r_trojan_flag;
    assign timeout_err = r_timeout_err;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
